apb_slv_mux: RTL and testbench
==============================

// Module: apb_slv_mux
// PURPOSE
//  APB fan-out stage directly downstream of the AHB-to-APB bridge interface. Decodes the shared
//  APB address into one-hot slave selects and muxes the selected slave's prdata/pready/pslverr
//  back to the bridge. It also terminates two fault cases itself: unmapped addresses and slaves
//  that hang. Error address and type are held in sticky status registers for firmware and debug.
// PARAMETERS
//  NUM_SLV      12    number of APB slaves (1..16)
//  SEL_LSB      12    lowest paddr bit of the slave index field (4 KB window per slave)
//  SEL_W        4     width of the slave index field, paddr[SEL_LSB+SEL_W-1:SEL_LSB]
//  TIMEOUT_CYC  256   max ACCESS cycles with pready low before forced termination; 0 = disabled
//  CNT_W        9     timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYC
// PORTS
//  hclk       in   1                      system clock (shared with the AHB side)
//  hreset     in   1                      synchronous reset, active-high
//  psel       in   1                      bridge-side APB select
//  penable    in   1                      bridge-side APB enable
//  paddr      in   `PADDR_WIDTH           bridge-side APB address
//  psel_x     out  NUM_SLV                one-hot slave selects; bit i drives psel_i
//  prdata_in  in   NUM_SLV*`APB_DATA_WIDTH  concatenated slave read data; slave i at slice i
//  pready_in  in   NUM_SLV                per-slave pready
//  pslverr_in in   NUM_SLV                per-slave pslverr
//  prdata     out  `APB_DATA_WIDTH        muxed read data to bridge
//  pready_x   out  1                      muxed/forced ready to bridge
//  pslverr_x  out  1                      muxed/forced slave error to bridge
//  err_valid  out  1                      sticky: at least one error captured since clear
//  err_type   out  2                      01 unmapped, 10 timeout, 11 protocol violation
//  err_addr   out  `PADDR_WIDTH           paddr of the first captured error
//  err_clr    in   1                      synchronous clear of err_valid, err_type and err_addr
// BEHAVIOUR
//  - idx = paddr[SEL_LSB+:SEL_W]. mapped = (idx < NUM_SLV). Decode is combinational; APB holds
//    paddr stable from SETUP through ACCESS.
//  - psel_x[i] = psel & mapped & (idx==i) & ~hreset. psel_x is 0 for unmapped addresses.
//  - Phase tracker register ph: IDLE, SETUP, ACCESS.
//    IDLE -> SETUP on psel & ~penable.
//    SETUP -> ACCESS on psel & penable.
//    ACCESS -> IDLE or SETUP when pready_x = 1 (per the next psel/penable).
//    ACCESS with pready_x = 0: stay in ACCESS.
//  - Protocol violation: penable = 1 while ph = IDLE, or psel dropped while ph = ACCESS and
//    pready_x = 0. Action: capture err type 11; ph returns to IDLE.
//  - Mapped ACCESS: prdata = prdata_in slice idx, pready_x = pready_in[idx],
//    pslverr_x = pslverr_in[idx].
//  - Unmapped ACCESS: pready_x = 1 and pslverr_x = 1 in the first ACCESS cycle (zero wait
//    states); prdata = 0. Capture err type 01.
//  - Outside ACCESS: prdata = 0, pready_x = 1, pslverr_x = 0.
//  - Timeout counter cnt:
//    cleared in IDLE/SETUP and on transfer completion; +1 per ACCESS cycle with pready_in[idx] = 0.
//    When TIMEOUT_CYC != 0 and cnt == TIMEOUT_CYC-1 with pready low: force pready_x = 1,
//    pslverr_x = 1, prdata = 0 for that one cycle; capture err type 10.
//    Total access length when timed out = TIMEOUT_CYC cycles.
//    The slave keeps psel until the bridge drops it; the late slave response is ignored.
//  - If the slave raises pready in the same cycle the timeout would fire, the slave response wins
//    and no error is recorded.
//  - Error capture: only when err_valid = 0 (first error wins); err_valid then set.
//    err_clr in the same cycle as a new error: the clear wins and the new error is dropped.
//  - Reset: all registers clear (ph = IDLE, cnt = 0, err_* = 0). psel_x = 0, prdata = 0,
//    pready_x = 1, pslverr_x = 0 while hreset is high. Reset mid-transfer abandons the transfer.
//  - Latency: zero-cycle combinational mux path; no pipelining, so no added wait states.
// STRUCTURE
//  - Shared package/include: `PADDR_WIDTH, `APB_DATA_WIDTH, and the 2-bit err_type encodings
//    ERR_NONE/UNMAP/TIMEOUT/PROTO. The phase encoding is local to this module.
//  - One natural sub-module: apb_slv_timeout (phase tracker + timeout counter). It outputs
//    timeout_fire and proto_err; apb_slv_mux keeps decode, mux and error capture.
//  - Instantiated in apb_top between the bridge interface (paddr/psel/penable, pready_x/pslverr_x)
//    and the 12 slave ports.
// TESTING
//  1 Write to paddr 0x0000_3004, slave 3 pready = 1 immediately
//    -> psel_x = 12'h008 in SETUP and ACCESS; pready_x = 1 and pslverr_x = 0 in the first
//       ACCESS cycle.
//  2 Read paddr 0x0000_5010, slave 5 returns 0xCAFE_F00D after 3 wait states
//    -> pready_x low for 3 cycles, then prdata = 0xCAFE_F00D with pready_x = 1; no error captured.
//  3 Access paddr 0x0000_C000 (idx 12, unmapped)
//    -> psel_x = 0; first ACCESS cycle pready_x = 1, pslverr_x = 1, prdata = 0;
//       err_type = 01, err_addr = 0x0000_C000.
//  4 TIMEOUT_CYC = 8, slave 0 holds pready = 0
//    -> 8th ACCESS cycle pready_x = 1, pslverr_x = 1; err_type = 10.
//       Repeat with pready rising in the 8th cycle -> normal completion, err_valid stays 0.
//  5 Unmapped error then timeout error without err_clr
//    -> err_addr/err_type keep the first error. Assert err_clr -> err_valid = 0 next cycle.
//  6 hreset asserted mid-ACCESS with slave 7 stalled
//    -> next cycle psel_x = 0, pready_x = 1, cnt = 0, err_* = 0. Also penable without SETUP
//       -> err_type = 11.

Source files
------------

// File: rtl/apb_slv_mux_pkg.sv
// apb_slv_mux_pkg
//   Shared definitions for the APB slave fan-out stage: bus widths and the
//   2-bit error-type codes reported in the sticky status registers.
package apb_slv_mux_pkg;

  localparam int PADDR_WIDTH    = 32;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_UNMAP   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_PROTO   = 2'b11
  } err_type_e;

endpackage

// File: rtl/apb_slv_timeout.sv
// apb_slv_timeout
//   APB phase tracker and hung-slave timeout counter.
//   Ports:
//     hclk, hreset  clock, synchronous active-high reset
//     psel, penable bridge-side APB control
//     mapped        current paddr decodes to an existing slave
//     pready_slv    pready of the decoded slave (0 when unmapped)
//     in_access     this cycle is a valid ACCESS cycle of a tracked transfer
//     timeout_fire  force-terminate this ACCESS cycle (slave hung too long)
//     proto_err     APB sequencing violation seen this cycle
module apb_slv_timeout
  import apb_slv_mux_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic hclk,
  input  logic hreset,
  input  logic psel,
  input  logic penable,
  input  logic mapped,
  input  logic pready_slv,
  output logic in_access,
  output logic timeout_fire,
  output logic proto_err
);

  // ph records what the tracker expects of the current cycle:
  //   PH_IDLE   no transfer open; a SETUP may start one
  //   PH_SETUP  SETUP seen last cycle; this cycle is the first ACCESS
  //   PH_ACCESS previous ACCESS cycle stalled; this cycle continues it
  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_SETUP  = 2'b01,
    PH_ACCESS = 2'b10
  } ph_e;

  localparam bit               TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  ph_e              ph, ph_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             done;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of block evaluation order.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      ph  <= PH_IDLE;
      cnt <= '0;
    end else begin
      ph  <= ph_nxt;
      cnt <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    ph_nxt       = ph;
    in_access    = ~hreset & psel & penable & (ph != PH_IDLE);
    // Slave raising pready in the firing cycle wins over the timeout.
    timeout_fire = TO_EN & in_access & mapped & ~pready_slv & (cnt == TO_LAST);
    // Transfer completes when the bridge will see pready_x high.
    done         = ~mapped | pready_slv | timeout_fire;
    proto_err    = ~hreset & (((ph == PH_IDLE) & penable) | ((ph == PH_ACCESS) & ~psel));

    unique case (ph)
      PH_IDLE: begin
        if (psel && !penable) ph_nxt = PH_SETUP;
      end
      PH_SETUP, PH_ACCESS: begin
        if (!psel)        ph_nxt = PH_IDLE;
        else if (penable) ph_nxt = done ? PH_IDLE : PH_ACCESS;
        else              ph_nxt = PH_SETUP;
      end
      default: ph_nxt = PH_IDLE;
    endcase

    // Counts stalled ACCESS cycles; anything else (idle, setup, completion) clears it.
    cnt_nxt = (in_access && !done) ? cnt + CNT_W'(1) : '0;
  end

endmodule

// File: rtl/apb_slv_mux.sv
// apb_slv_mux
//   APB fan-out stage behind the AHB-to-APB bridge. Decodes paddr into one-hot
//   slave selects, muxes the selected slave's response back to the bridge,
//   terminates unmapped and hung accesses itself, and keeps the first error in
//   sticky status registers.
//   Ports:
//     hclk, hreset          clock, synchronous active-high reset
//     psel, penable, paddr  bridge-side APB request
//     psel_x                one-hot slave selects
//     prdata_in/pready_in/pslverr_in  concatenated slave responses
//     prdata, pready_x, pslverr_x     response to the bridge
//     err_valid/err_type/err_addr     sticky first-error status
//     err_clr               synchronous clear of the error status
module apb_slv_mux
  import apb_slv_mux_pkg::*;
#(
  parameter int NUM_SLV     = 12,
  parameter int SEL_LSB     = 12,
  parameter int SEL_W       = 4,
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 9
) (
  input  logic                              hclk,
  input  logic                              hreset,
  input  logic                              psel,
  input  logic                              penable,
  input  logic [PADDR_WIDTH-1:0]            paddr,
  output logic [NUM_SLV-1:0]                psel_x,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] prdata_in,
  input  logic [NUM_SLV-1:0]                pready_in,
  input  logic [NUM_SLV-1:0]                pslverr_in,
  output logic [APB_DATA_WIDTH-1:0]         prdata,
  output logic                              pready_x,
  output logic                              pslverr_x,
  output logic                              err_valid,
  output logic [1:0]                        err_type,
  output logic [PADDR_WIDTH-1:0]            err_addr,
  input  logic                              err_clr
);

  logic [SEL_W-1:0]          idx;
  logic                      mapped;
  logic [APB_DATA_WIDTH-1:0] slv_rdata;
  logic                      slv_ready;
  logic                      slv_err;
  logic                      in_access;
  logic                      timeout_fire;
  logic                      proto_err;
  logic                      new_err;
  err_type_e                 new_type;
  err_type_e                 err_type_q;

  assign idx = paddr[SEL_LSB +: SEL_W];

  // Decode and slave-response select. Indices >= NUM_SLV match no slave,
  // which is what marks the address unmapped.
  always_comb begin
    mapped    = 1'b0;
    psel_x    = '0;
    slv_rdata = '0;
    slv_ready = 1'b0;
    slv_err   = 1'b0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx == SEL_W'(i)) begin
        mapped    = 1'b1;
        psel_x[i] = psel & ~hreset;
        slv_rdata = prdata_in[i*APB_DATA_WIDTH +: APB_DATA_WIDTH];
        slv_ready = pready_in[i];
        slv_err   = pslverr_in[i];
      end
    end
  end

  apb_slv_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .hclk         (hclk),
    .hreset       (hreset),
    .psel         (psel),
    .penable      (penable),
    .mapped       (mapped),
    .pready_slv   (slv_ready),
    .in_access    (in_access),
    .timeout_fire (timeout_fire),
    .proto_err    (proto_err)
  );

  // Bridge response: idle value outside ACCESS, forced error for unmapped or
  // timed-out accesses, otherwise a straight pass-through of the slave.
  always_comb begin
    prdata    = '0;
    pready_x  = 1'b1;
    pslverr_x = 1'b0;
    if (in_access) begin
      if (!mapped || timeout_fire) begin
        pslverr_x = 1'b1;
      end else begin
        prdata    = slv_rdata;
        pready_x  = slv_ready;
        pslverr_x = slv_err;
      end
    end
  end

  // Error sources are mutually exclusive: proto_err only occurs outside a
  // valid ACCESS cycle, the other two only inside one.
  always_comb begin
    new_err  = 1'b1;
    new_type = ERR_NONE;
    if (proto_err)                  new_type = ERR_PROTO;
    else if (in_access && !mapped)  new_type = ERR_UNMAP;
    else if (timeout_fire)          new_type = ERR_TIMEOUT;
    else                            new_err  = 1'b0;
  end

  // First error wins; a clear in the same cycle as a new error drops it.
  always_ff @(posedge hclk) begin
    if (hreset || err_clr) begin
      err_valid  <= 1'b0;
      err_type_q <= ERR_NONE;
      err_addr   <= '0;
    end else if (new_err && !err_valid) begin
      err_valid  <= 1'b1;
      err_type_q <= new_type;
      err_addr   <= paddr;
    end
  end

  assign err_type = err_type_q;

endmodule

// File: tb/tb_apb_slv_mux.sv
module tb_apb_slv_mux;
  import apb_slv_mux_pkg::*;

  localparam int NS = 12;
  localparam int TO = 8;
  localparam int DW = APB_DATA_WIDTH;
  localparam int AW = PADDR_WIDTH;

  logic            hclk = 1'b0;
  logic            hreset, psel, penable, err_clr;
  logic [AW-1:0]   paddr;
  logic [NS-1:0]   psel_x, pready_in, pslverr_in;
  logic [NS*DW-1:0] prdata_in;
  logic [DW-1:0]   prdata;
  logic            pready_x, pslverr_x, err_valid;
  logic [1:0]      err_type;
  logic [AW-1:0]   err_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model of the sticky error status.
  bit            m_valid;
  logic [1:0]    m_type;
  logic [AW-1:0] m_addr;

  apb_slv_mux #(
    .NUM_SLV(NS), .SEL_LSB(12), .SEL_W(4), .TIMEOUT_CYC(TO), .CNT_W(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .psel(psel), .penable(penable), .paddr(paddr),
    .psel_x(psel_x), .prdata_in(prdata_in), .pready_in(pready_in),
    .pslverr_in(pslverr_in), .prdata(prdata), .pready_x(pready_x),
    .pslverr_x(pslverr_x), .err_valid(err_valid), .err_type(err_type),
    .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 hclk = ~hclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic randomize_slaves();
    for (int i = 0; i < NS; i++) prdata_in[i*DW +: DW] = $urandom;
    pready_in  = NS'($urandom);
    pslverr_in = NS'($urandom);
  endtask

  function automatic void model_err(input logic [1:0] t, input logic [AW-1:0] a);
    if (!m_valid) begin
      m_valid = 1'b1;
      m_type  = t;
      m_addr  = a;
    end
  endfunction

  function automatic void model_clear();
    m_valid = 1'b0;
    m_type  = ERR_NONE;
    m_addr  = '0;
  endfunction

  task automatic check_err(input string tag);
    check({tag, " err_valid"}, err_valid, m_valid);
    check({tag, " err_type"},  err_type,  m_type);
    check({tag, " err_addr"},  err_addr,  m_addr);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " pready_x"},  pready_x,  1'b1);
    check({tag, " pslverr_x"}, pslverr_x, 1'b0);
    check({tag, " prdata"},    prdata,    '0);
  endtask

  // One complete APB transfer. The selected slave answers after wait_n wait
  // states; every other slave drives random noise.
  task automatic do_xfer(input string tag, input logic [AW-1:0] addr, input int wait_n,
                         input logic [DW-1:0] data, input logic slverr, input bit clr_last);
    int            idx;
    bit            mapped, timed_out, forced;
    int            len;
    logic [NS-1:0] exp_sel;
    idx       = int'((addr >> 12) & 32'hF);
    mapped    = (idx < NS);
    timed_out = mapped && (wait_n >= TO);
    forced    = !mapped || timed_out;
    len       = !mapped ? 1 : (timed_out ? TO : wait_n + 1);
    exp_sel   = mapped ? (NS'(1) << idx) : '0;

    next_cycle();
    randomize_slaves();
    psel = 1'b1; penable = 1'b0; paddr = addr;
    @(negedge hclk);
    check({tag, " setup psel_x"}, psel_x, exp_sel);
    check_idle_outputs({tag, " setup"});

    for (int k = 1; k <= len; k++) begin
      next_cycle();
      randomize_slaves();
      penable = 1'b1;
      if (mapped) begin
        pready_in[idx]          = (k > wait_n);
        pslverr_in[idx]         = slverr;
        prdata_in[idx*DW +: DW] = data;
      end
      err_clr = clr_last && (k == len);
      @(negedge hclk);
      check($sformatf("%s access%0d psel_x", tag, k), psel_x, exp_sel);
      check($sformatf("%s access%0d pready_x", tag, k), pready_x, (k == len));
      if (k == len) begin
        check({tag, " pslverr_x"}, pslverr_x, forced ? 1'b1 : slverr);
        check({tag, " prdata"},    prdata,    forced ? '0 : data);
      end
    end

    if (clr_last)       model_clear();
    else if (!mapped)   model_err(ERR_UNMAP, addr);
    else if (timed_out) model_err(ERR_TIMEOUT, addr);

    next_cycle();
    psel = 1'b0; penable = 1'b0; err_clr = 1'b0;
    randomize_slaves();
    @(negedge hclk);
    check_idle_outputs({tag, " post"});
    check_err({tag, " post"});
  endtask

  task automatic clear_err(input string tag);
    next_cycle();
    err_clr = 1'b1;
    next_cycle();
    err_clr = 1'b0;
    model_clear();
    @(negedge hclk);
    check_err({tag, " clear"});
  endtask

  typedef struct {
    string         name;
    logic [AW-1:0] addr;
    int            wait_n;
    logic [DW-1:0] data;
    logic          slverr;
    bit            clr_last;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"t1_slv3_write",     32'h0000_3004, 0,   32'h1357_9BDF, 1'b0, 1'b0};
    vecs[1] = '{"t2_slv5_wait3",     32'h0000_5010, 3,   32'hCAFE_F00D, 1'b0, 1'b0};
    vecs[2] = '{"t4b_slv0_late_ok",  32'h0000_0004, 7,   32'h0BAD_BEEF, 1'b0, 1'b0};
    vecs[3] = '{"slv11_slverr",      32'h0000_B0FC, 1,   32'h5A5A_A5A5, 1'b1, 1'b0};
    vecs[4] = '{"t3_unmapped_c",     32'h0000_C000, 0,   32'h1111_2222, 1'b0, 1'b0};
    vecs[5] = '{"t5_timeout_kept",   32'h0000_0008, 100, 32'h3333_4444, 1'b0, 1'b0};
    vecs[6] = '{"unmapped_f_clr",    32'h0000_F000, 0,   32'h5555_6666, 1'b0, 1'b1};
    vecs[7] = '{"t4_timeout_first",  32'h0000_0010, 100, 32'h7777_8888, 1'b0, 1'b0};

    hreset = 1'b1; psel = 1'b0; penable = 1'b0; err_clr = 1'b0; paddr = '0;
    randomize_slaves();
    model_clear();
    repeat (2) next_cycle();
    psel = 1'b1; paddr = 32'h0000_3000;
    @(negedge hclk);
    check("reset psel_x", psel_x, '0);
    check_idle_outputs("reset");
    check_err("reset");
    next_cycle();
    psel = 1'b0; hreset = 1'b0;

    // Directed table.
    foreach (vecs[i])
      do_xfer(vecs[i].name, vecs[i].addr, vecs[i].wait_n, vecs[i].data,
              vecs[i].slverr, vecs[i].clr_last);
    clear_err("t5");

    // Randomized transfers against the model.
    for (int n = 0; n < 40; n++) begin
      do_xfer($sformatf("rnd%0d", n), $urandom, $urandom_range(0, 10), $urandom,
              1'($urandom), ($urandom_range(0, 5) == 0));
    end
    clear_err("rnd");

    // penable with no preceding SETUP.
    next_cycle();
    paddr = 32'h0000_2000; psel = 1'b0; penable = 1'b1;
    @(negedge hclk);
    check("proto_pen psel_x", psel_x, '0);
    check_idle_outputs("proto_pen");
    next_cycle();
    penable = 1'b0;
    model_err(ERR_PROTO, 32'h0000_2000);
    @(negedge hclk);
    check_err("proto_pen");
    clear_err("proto_pen");

    // psel dropped while slave 2 is stalling.
    next_cycle();
    randomize_slaves();
    paddr = 32'h0000_2040; psel = 1'b1; penable = 1'b0;
    next_cycle();
    penable = 1'b1; pready_in[2] = 1'b0;
    @(negedge hclk);
    check("proto_drop stall pready_x", pready_x, 1'b0);
    next_cycle();
    psel = 1'b0; penable = 1'b0;
    next_cycle();
    model_err(ERR_PROTO, 32'h0000_2040);
    @(negedge hclk);
    check_err("proto_drop");

    // Reset in the middle of a stalled access to slave 7; error status is set.
    next_cycle();
    randomize_slaves();
    paddr = 32'h0000_7000; psel = 1'b1; penable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      penable = 1'b1; pready_in[7] = 1'b0;
      @(negedge hclk);
      check($sformatf("rst_mid stall%0d pready_x", k), pready_x, 1'b0);
    end
    next_cycle();
    hreset = 1'b1;
    @(negedge hclk);
    check("rst_mid psel_x", psel_x, '0);
    check_idle_outputs("rst_mid");
    next_cycle();
    psel = 1'b0; penable = 1'b0;
    model_clear();
    @(negedge hclk);
    check_err("rst_mid");
    next_cycle();
    hreset = 1'b0;
    // Counter must restart from zero: timeout lands exactly on cycle TO.
    do_xfer("rst_after_timeout", 32'h0000_7000, 100, 32'h9999_AAAA, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
